// File: rtl/seg_scan_ctrl_pkg.sv
// Shared segment codes, scan state encoding and helpers for the 7-segment scan controller.
package seg_scan_ctrl_pkg;

    // Segment order {a,b,c,d,e,f,g}, active-high.
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        longint unsigned v;
        r = 0;
        v = 1;
        while (v < longint'(n)) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_bcd_dec.sv
// BCD to 7-segment decoder; codes 10-15 decode to an all-off pattern.
module seg_scan_ctrl_bcd_dec
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Each slot is a blank gap followed by a drive phase; the displayed value only changes at frame wrap.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int unsigned N_DIGITS     = 4,
    parameter int unsigned PRESCALE     = 50000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic                  load,
    input  logic                  lz_suppress,
    output logic [6:0]            seg,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_done
);

    localparam int unsigned CW = (clog2(PRESCALE) > 0) ? clog2(PRESCALE) : 1;
    localparam int unsigned IW = (clog2(N_DIGITS) > 0) ? clog2(N_DIGITS) : 1;
    localparam int unsigned DRIVE_LAST = PRESCALE - BLANK_CYCLES - 1;
    localparam int unsigned BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
    localparam logic [CW-1:0] DRIVE_TC = CW'(DRIVE_LAST);
    localparam logic [CW-1:0] BLANK_TC = CW'(BLANK_LAST);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_DIGITS - 1);
    localparam scan_state_t SLOT_START = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

    scan_state_t           state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
    logic [4*N_DIGITS-1:0] display_q, display_d;
    logic                  pending_q, pending_d;
    logic [6:0]            seg_q, seg_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic                  frame_done_q, frame_done_d;

    logic                  wrap;
    logic [N_DIGITS-1:0]   lz_mask;
    logic                  zero_run;
    logic [3:0]            dec_bcd;
    logic [6:0]            dec_seg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            shadow_q     <= '0;
            display_q    <= '0;
            pending_q    <= 1'b0;
            seg_q        <= SEG_BLANK;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            display_q    <= display_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        display_d = display_q;
        pending_d = pending_q;
        wrap      = 1'b0;

        if (load) begin
            shadow_d  = value;
            pending_d = 1'b1;
        end

        if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SLOT_START;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                BLANK: begin
                    if (cnt_q == BLANK_TC) begin
                        state_d = DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt_q == DRIVE_TC) begin
                        state_d = SLOT_START;
                        cnt_d   = '0;
                        if (idx_q == LAST_IDX) begin
                            wrap  = 1'b1;
                            idx_d = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        // A load on the wrap edge bypasses the shadow so the new value starts this frame.
        if (wrap && (load || pending_q)) begin
            display_d = load ? value : shadow_q;
            pending_d = 1'b0;
        end
    end

    // Digit i is a leading zero when it and every more significant nibble are zero.
    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            zero_run   = zero_run & (display_d[4*i +: 4] == 4'd0);
            lz_mask[i] = zero_run;
        end
    end

    assign dec_bcd = display_d[4*int'(idx_d) +: 4];

    seg_scan_ctrl_bcd_dec u_bcd_dec (
        .bcd (dec_bcd),
        .seg (dec_seg)
    );

    // Outputs are computed from the next state so they move on the same edge as the FSM.
    always_comb begin
        an_d         = '1;
        seg_d        = SEG_BLANK;
        frame_done_d = wrap;
        if (state_d == DRIVE) begin
            an_d[idx_d] = 1'b0;
            if (!(lz_suppress && lz_mask[idx_d])) begin
                seg_d = dec_seg;
            end
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a phase-based reference model.
module tb_seg_scan_ctrl;

    localparam int N      = 4;
    localparam int PRE    = 8;
    localparam int BLK    = 2;
    localparam int FRAME  = N * PRE;

    logic          clk;
    logic          rst;
    logic          enable;
    logic [15:0]   value;
    logic          load;
    logic          lz_suppress;
    logic [6:0]    seg;
    logic [3:0]    an;
    logic          frame_done;

    int vectors;
    int miscompares;

    // Reference model: phase = cycles since the edge that left IDLE, -1 while idle.
    int            m_phase;
    logic [15:0]   m_disp;
    logic [15:0]   m_shadow;
    logic          m_pending;
    logic [3:0]    m_an;
    logic [6:0]    m_seg;
    logic          m_fd;
    logic [6:0]    seg_tbl [16];

    seg_scan_ctrl #(
        .N_DIGITS     (N),
        .PRESCALE     (PRE),
        .BLANK_CYCLES (BLK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .value       (value),
        .load        (load),
        .lz_suppress (lz_suppress),
        .seg         (seg),
        .an          (an),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_phase   = -1;
        m_disp    = 16'h0;
        m_shadow  = 16'h0;
        m_pending = 1'b0;
        m_an      = 4'hF;
        m_seg     = 7'h0;
        m_fd      = 1'b0;
    endtask

    // Advance one clock and update expectations from the inputs seen at that edge.
    task automatic tick();
        int pos;
        int dig;
        logic [3:0] nib;
        @(posedge clk);
        m_fd = 1'b0;
        if (!enable) begin
            m_phase = -1;
        end else begin
            m_phase = m_phase + 1;
            if (m_phase > 0 && m_phase % FRAME == 0) begin
                m_fd = 1'b1;
                if (load) begin
                    m_disp    = value;
                    m_pending = 1'b0;
                end else if (m_pending) begin
                    m_disp    = m_shadow;
                    m_pending = 1'b0;
                end
            end
        end
        if (load) begin
            m_shadow = value;
            if (!m_fd) m_pending = 1'b1;
        end
        m_an  = 4'hF;
        m_seg = 7'h0;
        if (m_phase >= 0) begin
            pos = m_phase % PRE;
            dig = (m_phase / PRE) % N;
            if (pos >= BLK) begin
                m_an[dig] = 1'b0;
                nib = 4'((m_disp >> (4 * dig)) & 16'hF);
                if (!(lz_suppress && dig > 0 && (m_disp >> (4 * dig)) == 16'h0))
                    m_seg = seg_tbl[nib];
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (an !== 4'hF || seg !== 7'h0 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold an=%b seg=%b fd=%b required 1111/0000000/0", an, seg, frame_done);
        end
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (an !== m_an || seg !== m_seg || frame_done !== m_fd) begin
                miscompares++;
                $display("FAIL reset_run ph=%0d an=%b/%b seg=%b/%b fd=%b/%b",
                         m_phase, an, m_an, seg, m_seg, frame_done, m_fd);
            end
        end
        // Mid-drive of digit 0: reset must clear outputs without a clock edge.
        #3 rst = 1'b1;
        #1;
        vectors++;
        if (an !== 4'hF || seg !== 7'h0 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async an=%b seg=%b fd=%b required 1111/0000000/0", an, seg, frame_done);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        enable = 1'b0;
        model_reset();
    endtask

    task automatic test_basic_scan();
        value = 16'h1234;
        load = 1'b1;
        enable = 1'b1;
        lz_suppress = 1'b0;
        for (int k = 0; k <= 2 * FRAME; k++) begin
            tick();
            load = 1'b0;
            vectors++;
            if (an !== m_an || seg !== m_seg || frame_done !== m_fd) begin
                miscompares++;
                $display("FAIL basic ph=%0d an=%b/%b seg=%b/%b fd=%b/%b",
                         m_phase, an, m_an, seg, m_seg, frame_done, m_fd);
            end
            if (k == 34) begin
                vectors++;
                if (an !== 4'b1110 || seg !== 7'b0110011) begin
                    miscompares++;
                    $display("FAIL basic_digit0 an=%b seg=%b required 1110/0110011", an, seg);
                end
            end
            if (k == 58) begin
                vectors++;
                if (an !== 4'b0111 || seg !== 7'b0110000) begin
                    miscompares++;
                    $display("FAIL basic_digit3 an=%b seg=%b required 0111/0110000", an, seg);
                end
            end
            if (k == 31 || k == 32 || k == 64) begin
                vectors++;
                if (frame_done !== (k != 31)) begin
                    miscompares++;
                    $display("FAIL basic_frame_done k=%0d fd=%b required %b", k, frame_done, k != 31);
                end
            end
        end
    endtask

    task automatic test_lz_suppress();
        int base;
        int rel;
        base = (m_phase / FRAME + 1) * FRAME;
        value = 16'h0070;
        load = 1'b1;
        lz_suppress = 1'b1;
        while (m_phase < base + 2 * FRAME) begin
            tick();
            load = 1'b0;
            vectors++;
            if (an !== m_an || seg !== m_seg || frame_done !== m_fd) begin
                miscompares++;
                $display("FAIL lz ph=%0d an=%b/%b seg=%b/%b fd=%b/%b",
                         m_phase, an, m_an, seg, m_seg, frame_done, m_fd);
            end
            rel = m_phase - base;
            if (rel >= 0 && rel < FRAME && rel % PRE == 4) begin
                vectors++;
                case (rel / PRE)
                    0: if (seg !== 7'b1111110 || an !== 4'b1110) begin
                        miscompares++;
                        $display("FAIL lz_d0 seg=%b an=%b required 1111110/1110", seg, an);
                    end
                    1: if (seg !== 7'b1110000 || an !== 4'b1101) begin
                        miscompares++;
                        $display("FAIL lz_d1 seg=%b an=%b required 1110000/1101", seg, an);
                    end
                    default: if (seg !== 7'b0000000 || an[rel / PRE] !== 1'b0) begin
                        miscompares++;
                        $display("FAIL lz_d%0d seg=%b an=%b required 0000000 with anode low",
                                 rel / PRE, seg, an);
                    end
                endcase
            end
            if (rel == FRAME - 1) lz_suppress = 1'b0;
            if (rel == FRAME + 20 || rel == FRAME + 28) begin
                vectors++;
                if (seg !== 7'b1111110) begin
                    miscompares++;
                    $display("FAIL lz_off rel=%0d seg=%b required 1111110", rel, seg);
                end
            end
        end
    endtask

    task automatic test_tear_free_load();
        int base;
        int rel;
        while (m_phase % FRAME != 11) begin
            tick();
            vectors++;
            if (an !== m_an || seg !== m_seg || frame_done !== m_fd) begin
                miscompares++;
                $display("FAIL tear_pre ph=%0d an=%b/%b seg=%b/%b fd=%b/%b",
                         m_phase, an, m_an, seg, m_seg, frame_done, m_fd);
            end
        end
        base = m_phase - 11;
        value = 16'h9999;
        load = 1'b1;
        while (m_phase < base + 2 * FRAME) begin
            tick();
            load = 1'b0;
            vectors++;
            if (an !== m_an || seg !== m_seg || frame_done !== m_fd) begin
                miscompares++;
                $display("FAIL tear ph=%0d an=%b/%b seg=%b/%b fd=%b/%b",
                         m_phase, an, m_an, seg, m_seg, frame_done, m_fd);
            end
            rel = m_phase - base;
            if (rel == 20 || rel == 28) begin
                vectors++;
                if (seg !== 7'b1111110) begin
                    miscompares++;
                    $display("FAIL tear_old rel=%0d seg=%b required 1111110", rel, seg);
                end
            end
            if (rel >= FRAME && rel % PRE == 4) begin
                vectors++;
                if (seg !== 7'b1111011) begin
                    miscompares++;
                    $display("FAIL tear_new rel=%0d seg=%b required 1111011", rel, seg);
                end
            end
        end
        while (m_phase % FRAME != FRAME - 1) begin
            tick();
            vectors++;
            if (an !== m_an || seg !== m_seg || frame_done !== m_fd) begin
                miscompares++;
                $display("FAIL tear_wait ph=%0d an=%b/%b seg=%b/%b fd=%b/%b",
                         m_phase, an, m_an, seg, m_seg, frame_done, m_fd);
            end
        end
        // Load presented on the wrap edge itself.
        value = 16'h5555;
        load = 1'b1;
        base = m_phase + 1;
        while (m_phase < base + 2 * PRE) begin
            tick();
            load = 1'b0;
            vectors++;
            if (an !== m_an || seg !== m_seg || frame_done !== m_fd) begin
                miscompares++;
                $display("FAIL wrap_load ph=%0d an=%b/%b seg=%b/%b fd=%b/%b",
                         m_phase, an, m_an, seg, m_seg, frame_done, m_fd);
            end
            rel = m_phase - base;
            if (rel == 4 || rel == 12) begin
                vectors++;
                if (seg !== 7'b1011011) begin
                    miscompares++;
                    $display("FAIL wrap_load_new rel=%0d seg=%b required 1011011", rel, seg);
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        for (int pass = 0; pass < 2; pass++) begin
            // Pass 0 drops in the 3rd drive cycle of digit 2, pass 1 on the wrap edge.
            while (m_phase % FRAME != (pass == 0 ? 20 : FRAME - 1)) begin
                tick();
                vectors++;
                if (an !== m_an || seg !== m_seg || frame_done !== m_fd) begin
                    miscompares++;
                    $display("FAIL drop_pre ph=%0d an=%b/%b seg=%b/%b fd=%b/%b",
                             m_phase, an, m_an, seg, m_seg, frame_done, m_fd);
                end
            end
            enable = 1'b0;
            tick();
            vectors++;
            if (an !== 4'hF || seg !== 7'h0 || frame_done !== 1'b0) begin
                miscompares++;
                $display("FAIL drop_off pass=%0d an=%b seg=%b fd=%b required 1111/0000000/0",
                         pass, an, seg, frame_done);
            end
            tick();
            tick();
            enable = 1'b1;
            for (int k = 0; k < 3; k++) begin
                tick();
                vectors++;
                if (an !== m_an || seg !== m_seg || frame_done !== m_fd) begin
                    miscompares++;
                    $display("FAIL reenable ph=%0d an=%b/%b seg=%b/%b fd=%b/%b",
                             m_phase, an, m_an, seg, m_seg, frame_done, m_fd);
                end
            end
            vectors++;
            if (an !== 4'b1110 || seg !== 7'b1011011) begin
                miscompares++;
                $display("FAIL reenable_d0 an=%b seg=%b required 1110/1011011", an, seg);
            end
        end
    endtask

    task automatic test_invalid_bcd();
        int base;
        int rel;
        base = (m_phase / FRAME + 1) * FRAME;
        value = 16'h00A5;
        load = 1'b1;
        lz_suppress = 1'b1;
        while (m_phase < base + FRAME) begin
            tick();
            load = 1'b0;
            vectors++;
            if (an !== m_an || seg !== m_seg || frame_done !== m_fd) begin
                miscompares++;
                $display("FAIL invalid ph=%0d an=%b/%b seg=%b/%b fd=%b/%b",
                         m_phase, an, m_an, seg, m_seg, frame_done, m_fd);
            end
            rel = m_phase - base;
            if (rel >= 0 && rel % PRE == 4) begin
                vectors++;
                if (an !== ~(4'b0001 << (rel / PRE)) ||
                    seg !== ((rel / PRE == 0) ? 7'b1011011 : 7'b0000000)) begin
                    miscompares++;
                    $display("FAIL invalid_d%0d an=%b seg=%b", rel / PRE, an, seg);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] v;
        for (int k = 0; k < 600; k++) begin
            for (int n = 0; n < 4; n++)
                v[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            value = v;
            load = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) lz_suppress = ~lz_suppress;
            if (enable) enable = ($urandom_range(0, 79) != 0);
            else enable = ($urandom_range(0, 3) == 0);
            tick();
            vectors++;
            if (an !== m_an || seg !== m_seg || frame_done !== m_fd) begin
                miscompares++;
                $display("FAIL random k=%0d ph=%0d an=%b/%b seg=%b/%b fd=%b/%b",
                         k, m_phase, an, m_an, seg, m_seg, frame_done, m_fd);
            end
        end
        load = 1'b0;
    endtask

    initial begin
        seg_tbl[0]  = 7'b1111110;
        seg_tbl[1]  = 7'b0110000;
        seg_tbl[2]  = 7'b1101101;
        seg_tbl[3]  = 7'b1111001;
        seg_tbl[4]  = 7'b0110011;
        seg_tbl[5]  = 7'b1011011;
        seg_tbl[6]  = 7'b1011111;
        seg_tbl[7]  = 7'b1110000;
        seg_tbl[8]  = 7'b1111111;
        seg_tbl[9]  = 7'b1111011;
        for (int i = 10; i < 16; i++) seg_tbl[i] = 7'b0000000;
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        enable = 1'b0;
        value = 16'h0;
        load = 1'b0;
        lz_suppress = 1'b0;
        model_reset();

        test_reset();
        test_basic_scan();
        test_lz_suppress();
        test_tear_free_load();
        test_enable_drop();
        test_invalid_bcd();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
